// File: rtl/symbol_packer.sv
// Packs 1/2/4/8-bit symbols MSB-first into OUT_W-bit words, with
// zero-padded flush of partial words and a registered fill count.
//
// state | meaning
// EMPTY | fill = 0; the next accepted symbol latches mode
// PACK  | fill > 0; cur_mode governs symbol width until word done/flush
module symbol_packer #(
  parameter int OUT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             data_in,
  input  logic [1:0]             mode,
  input  logic                   flush,
  output logic [OUT_W-1:0]       data_o,
  output logic                   data_en,
  output logic                   pad_o,
  output logic [$clog2(OUT_W):0] fill
);

  localparam int FW = $clog2(OUT_W) + 1;

  typedef enum logic {EMPTY, PACK} state_t;

  state_t           state, state_n;
  logic [OUT_W-1:0] sr, sr_n, sr_acc, data_n;
  logic [FW-1:0]    fill_n, fill_acc, pad_shift;
  logic [1:0]       cur_mode, cur_mode_n, eff_mode;
  logic [3:0]       w;
  logic [7:0]       sym;
  logic             en_n, pad_n, word_done, part_flush;

  // Accept path: flush decisions are taken on the post-accept fill.
  always_comb begin
    eff_mode = (state == EMPTY) ? mode : cur_mode;
    w        = 4'd8;
    sym      = data_in;
    case (eff_mode)
      2'd0: begin w = 4'd1; sym = {7'b0, data_in[0]};   end
      2'd1: begin w = 4'd2; sym = {6'b0, data_in[1:0]}; end
      2'd2: begin w = 4'd4; sym = {4'b0, data_in[3:0]}; end
      default: begin w = 4'd8; sym = data_in; end
    endcase
    sr_acc   = sr;
    fill_acc = fill;
    if (start) begin
      sr_acc   = (sr << w) | OUT_W'(sym);
      fill_acc = fill + FW'(w);
    end
    word_done  = (fill_acc == FW'(OUT_W));
    part_flush = flush && !word_done && (fill_acc != '0);
    pad_shift  = FW'(OUT_W) - fill_acc;
  end

  // Next-state
  always_comb begin
    cur_mode_n = (state == EMPTY && start) ? mode : cur_mode;
    if (word_done || part_flush) begin
      sr_n   = '0;
      fill_n = '0;
    end else begin
      sr_n   = sr_acc;
      fill_n = fill_acc;
    end
    state_n = (fill_n == '0) ? EMPTY : PACK;
  end

  // Output decode
  always_comb begin
    data_n = '0;
    en_n   = 1'b0;
    pad_n  = 1'b0;
    if (word_done) begin
      data_n = sr_acc;
      en_n   = 1'b1;
    end else if (part_flush) begin
      data_n = sr_acc << pad_shift;
      en_n   = 1'b1;
      pad_n  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      sr       <= '0;
      fill     <= '0;
      cur_mode <= 2'd3;
      data_o   <= '0;
      data_en  <= 1'b0;
      pad_o    <= 1'b0;
    end else begin
      state    <= state_n;
      sr       <= sr_n;
      fill     <= fill_n;
      cur_mode <= cur_mode_n;
      data_o   <= data_n;
      data_en  <= en_n;
      pad_o    <= pad_n;
    end
  end

endmodule

// File: tb/tb_symbol_packer.sv
// Scoreboard bench: directed symbol streams on an 8-bit and a 16-bit packer;
// expected words are queued at issue and matched by per-instance monitors.
module tb_symbol_packer;

  typedef struct {
    logic [15:0] data;
    logic        pad;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start8 = 1'b0, flush8 = 1'b0;
  logic [7:0]  din8 = '0;
  logic [1:0]  mode8 = '0;
  logic [7:0]  dout8;
  logic        en8, pad8;
  logic [3:0]  fill8;

  logic        start16 = 1'b0, flush16 = 1'b0;
  logic [7:0]  din16 = '0;
  logic [1:0]  mode16 = '0;
  logic [15:0] dout16;
  logic        en16, pad16;
  logic [4:0]  fill16;

  exp_t q8[$];
  exp_t q16[$];
  int   checks = 0;
  int   errors = 0;

  symbol_packer #(.OUT_W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .data_in(din8), .mode(mode8),
    .flush(flush8), .data_o(dout8), .data_en(en8), .pad_o(pad8), .fill(fill8)
  );

  symbol_packer #(.OUT_W(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .data_in(din16), .mode(mode16),
    .flush(flush16), .data_o(dout16), .data_en(en16), .pad_o(pad16), .fill(fill16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drv8(input logic s, input logic [7:0] d, input logic [1:0] m, input logic f);
    @(negedge clk);
    start8 = s; din8 = d; mode8 = m; flush8 = f;
  endtask

  task automatic drv16(input logic s, input logic [7:0] d, input logic [1:0] m, input logic f);
    @(negedge clk);
    start16 = s; din16 = d; mode16 = m; flush16 = f;
  endtask

  task automatic exp8(input logic [7:0] d, input logic p);
    exp_t e;
    e.data = 16'(d);
    e.pad  = p;
    q8.push_back(e);
  endtask

  task automatic exp16(input logic [15:0] d, input logic p);
    exp_t e;
    e.data = d;
    e.pad  = p;
    q16.push_back(e);
  endtask

  task automatic fill8_is(input logic [3:0] req);
    @(posedge clk);
    #1;
    chk("fill8", 32'(fill8), 32'(req));
  endtask

  task automatic fill16_is(input logic [4:0] req);
    @(posedge clk);
    #1;
    chk("fill16", 32'(fill16), 32'(req));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      checks++;
      if (en8) begin
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL w8_unexpected data_o=%0h pad_o=%0b required=no word", dout8, pad8);
        end else begin
          e = q8.pop_front();
          if (dout8 !== e.data[7:0] || pad8 !== e.pad) begin
            errors++;
            $display("FAIL w8_word data_o=%0h pad_o=%0b required=%0h pad=%0b",
                     dout8, pad8, e.data[7:0], e.pad);
          end
        end
      end else if (dout8 !== 8'h00 || pad8 !== 1'b0) begin
        errors++;
        $display("FAIL w8_idle data_o=%0h pad_o=%0b required=0/0", dout8, pad8);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      checks++;
      if (en16) begin
        if (q16.size() == 0) begin
          errors++;
          $display("FAIL w16_unexpected data_o=%0h pad_o=%0b required=no word", dout16, pad16);
        end else begin
          e = q16.pop_front();
          if (dout16 !== e.data || pad16 !== e.pad) begin
            errors++;
            $display("FAIL w16_word data_o=%0h pad_o=%0b required=%0h pad=%0b",
                     dout16, pad16, e.data, e.pad);
          end
        end
      end else if (dout16 !== 16'h0000 || pad16 !== 1'b0) begin
        errors++;
        $display("FAIL w16_idle data_o=%0h pad_o=%0b required=0/0", dout16, pad16);
      end
    end
  end

  initial begin
    logic [7:0] bits;

    #12;
    chk("rst_data8", 32'(dout8), 0);
    chk("rst_en8", 32'(en8), 0);
    chk("rst_pad8", 32'(pad8), 0);
    chk("rst_fill8", 32'(fill8), 0);
    chk("rst_fill16", 32'(fill16), 0);
    @(negedge clk);
    reset = 1'b0;

    // single byte
    drv8(1, 8'hA5, 3, 0); exp8(8'hA5, 0);
    fill8_is(0);
    drv8(0, 0, 0, 0);

    // two nibbles back to back
    drv8(1, 8'h0C, 2, 0); fill8_is(4);
    drv8(1, 8'h03, 2, 0); exp8(8'hC3, 0); fill8_is(0);

    // two nibbles with a 3-cycle gap
    drv8(1, 8'h0C, 2, 0); fill8_is(4);
    repeat (3) begin
      drv8(0, 0, 2, 0); fill8_is(4);
    end
    drv8(1, 8'h03, 2, 0); exp8(8'hC3, 0); fill8_is(0);

    // bit mode
    bits = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) drv8(1, {7'b0, bits[i]}, 0, 0);
    exp8(8'hB2, 0);
    fill8_is(0);

    // partial flush in 2-bit mode
    drv8(1, 8'h03, 1, 0);
    drv8(1, 8'h01, 1, 0); fill8_is(4);
    drv8(0, 0, 1, 1); exp8(8'hD0, 1); fill8_is(0);

    // flush while empty: no word
    drv8(0, 0, 0, 1); fill8_is(0);

    // flush together with completing symbol
    drv8(1, 8'h01, 1, 0);
    drv8(1, 8'h02, 1, 0);
    drv8(1, 8'h03, 1, 0); fill8_is(6);
    drv8(1, 8'h00, 1, 1); exp8(8'h6C, 0); fill8_is(0);

    // mode change mid-word is ignored
    drv8(1, 8'h0A, 2, 0);
    drv8(1, 8'h5F, 3, 0); exp8(8'hAF, 0);
    drv8(1, 8'h77, 3, 0); exp8(8'h77, 0); fill8_is(0);

    // start and flush together on a partial word
    drv8(1, 8'h09, 2, 1); exp8(8'h90, 1); fill8_is(0);
    drv8(0, 0, 0, 0);

    // 16-bit instance
    drv16(1, 8'h12, 3, 0); fill16_is(8);
    drv16(1, 8'h34, 3, 0); exp16(16'h1234, 0); fill16_is(0);
    drv16(1, 8'h0A, 2, 0); fill16_is(4);
    drv16(0, 0, 0, 1); exp16(16'hA000, 1); fill16_is(0);
    drv16(0, 0, 0, 0);

    // asynchronous reset mid-word
    drv8(1, 8'h0C, 2, 0); fill8_is(4);
    #2;
    start8 = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_fill8", 32'(fill8), 0);
    chk("async_en8", 32'(en8), 0);
    chk("async_data8", 32'(dout8), 0);
    @(negedge clk);
    reset = 1'b0;
    drv8(1, 8'h12, 3, 0); exp8(8'h12, 0); fill8_is(0);
    drv8(0, 0, 0, 0);

    repeat (4) @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 0);
    chk("q16_drained", 32'(q16.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
